// File: rtl/game_flow_responder.sv
// Responder for the game-flow controller phases.
// Draws screens/towers, tracks cars and lives, returns done pulses.
module game_flow_responder #(
  parameter int HOLD_CYCLES    = 25000000,
  parameter int CARS_PER_STAGE = 8,
  parameter int LIVES          = 3,
  parameter int NUM_TOWERS     = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wait_start,
  input  logic [2:0] stage_begin,
  input  logic [2:0] stage_draw_tower,
  input  logic [2:0] stage_in_progress,
  input  logic [2:0] stage_done,
  input  logic       win,
  input  logic       game_over_out,
  input  logic       start_key,
  input  logic       car_killed,
  input  logic       car_escaped,
  output logic       start_display_done,
  output logic [2:0] begin_done,
  output logic [2:0] tower_done,
  output logic [2:0] car_done,
  output logic [2:0] end_display_done,
  output logic       game_over_in,
  output logic       plot,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour
);

  typedef enum logic [3:0] {
    S_IDLE, S_SCREEN, S_HOLD, S_KEYWAIT, S_TOWER,
    S_PLAY, S_PULSE, S_FINAL, S_REARM
  } state_t;

  typedef enum logic [2:0] {
    K_TITLE, K_BEGIN, K_TOWER, K_PLAY, K_DONE, K_WIN, K_GO
  } kind_t;

  localparam logic [31:0] HLAST = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] TLAST = 32'(64 * NUM_TOWERS - 1);

  state_t      r_state;
  kind_t       r_kind;
  logic [1:0]  r_stg;
  logic [31:0] r_cnt;
  logic [7:0]  r_rem;
  logic [7:0]  r_lives;

  logic        w_any;
  kind_t       w_kind;
  logic [1:0]  w_stg;
  logic        w_live;
  logic [2:0]  w_sel;
  logic [2:0]  w_col;
  logic [7:0]  w_cars;
  logic [7:0]  w_dec;
  logic [7:0]  w_rem_n;
  logic [7:0]  w_liv_n;
  logic [31:0] w_nidx;
  logic [31:0] w_ti;
  logic [7:0]  w_tx;
  logic [6:0]  w_ty;

  function automatic logic [1:0] low3(input logic [2:0] v);
    return v[0] ? 2'd0 : (v[1] ? 2'd1 : 2'd2);
  endfunction

  // Pick the highest-priority active request
  always_comb begin
    w_any  = 1'b1;
    w_kind = K_TITLE;
    w_stg  = 2'd0;
    if (wait_start) begin
      w_kind = K_TITLE;
    end else if (|stage_begin) begin
      w_kind = K_BEGIN;
      w_stg  = low3(stage_begin);
    end else if (|stage_draw_tower) begin
      w_kind = K_TOWER;
      w_stg  = low3(stage_draw_tower);
    end else if (|stage_in_progress) begin
      w_kind = K_PLAY;
      w_stg  = low3(stage_in_progress);
    end else if (|stage_done) begin
      w_kind = K_DONE;
      w_stg  = low3(stage_done);
    end else if (win) begin
      w_kind = K_WIN;
    end else if (game_over_out) begin
      w_kind = K_GO;
    end else begin
      w_any  = 1'b0;
    end
  end

  // Is the latched request still asserted, plus per-kind helpers
  always_comb begin
    w_live = 1'b0;
    w_col  = 3'b000;
    case (r_kind)
      K_TITLE: begin w_live = wait_start;               w_col = 3'b001; end
      K_BEGIN: begin w_live = stage_begin[r_stg];       w_col = 3'b010; end
      K_TOWER: begin w_live = stage_draw_tower[r_stg];  w_col = 3'b011; end
      K_PLAY:  begin w_live = stage_in_progress[r_stg]; w_col = 3'b000; end
      K_DONE:  begin w_live = stage_done[r_stg];        w_col = 3'b110; end
      K_WIN:   begin w_live = win;                      w_col = 3'b111; end
      K_GO:    begin w_live = game_over_out;            w_col = 3'b100; end
      default: begin w_live = 1'b0;                     w_col = 3'b000; end
    endcase
  end

  // Car/lives arithmetic and tower raster addressing
  always_comb begin
    w_sel   = 3'b001 << r_stg;
    w_cars  = 8'(CARS_PER_STAGE * (32'(w_stg) + 1));
    w_dec   = {7'd0, car_killed} + {7'd0, car_escaped};
    w_rem_n = (r_rem > w_dec) ? r_rem - w_dec : 8'd0;
    w_liv_n = (car_escaped && r_lives != 8'd0) ? r_lives - 8'd1 : r_lives;
    w_nidx  = r_cnt + 32'd1;
    w_ti    = w_nidx >> 6;
    w_tx    = 8'(32'd16 + (w_ti << 5) + {29'd0, w_nidx[2:0]});
    w_ty    = 7'(32'd56 + {29'd0, w_nidx[5:3]});
  end

  // Main sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state            <= S_IDLE;
      r_kind             <= K_TITLE;
      r_stg              <= 2'd0;
      r_cnt              <= 32'd0;
      r_rem              <= 8'd0;
      r_lives            <= 8'd0;
      start_display_done <= 1'b0;
      begin_done         <= 3'b000;
      tower_done         <= 3'b000;
      car_done           <= 3'b000;
      end_display_done   <= 3'b000;
      game_over_in       <= 1'b0;
      plot               <= 1'b0;
      x                  <= 8'd0;
      y                  <= 7'd0;
      colour             <= 3'b000;
    end else begin
      start_display_done <= 1'b0;
      begin_done         <= 3'b000;
      tower_done         <= 3'b000;
      car_done           <= 3'b000;
      end_display_done   <= 3'b000;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_kind <= w_kind;
            r_stg  <= w_stg;
            r_cnt  <= 32'd0;
            if (w_kind == K_TOWER) begin
              r_state <= S_TOWER;
              plot    <= 1'b1;
              x       <= 8'd16;
              y       <= 7'd56;
              colour  <= 3'b011;
            end else if (w_kind == K_PLAY) begin
              r_state <= S_PLAY;
              r_rem   <= w_cars;
              if (w_stg == 2'd0) r_lives <= 8'(LIVES);
            end else begin
              r_state <= S_SCREEN;
              plot    <= 1'b1;
              x       <= 8'd0;
              y       <= 7'd0;
              case (w_kind)
                K_TITLE: colour <= 3'b001;
                K_BEGIN: colour <= 3'b010;
                K_DONE:  colour <= 3'b110;
                K_WIN:   colour <= 3'b111;
                default: colour <= 3'b100;
              endcase
            end
          end
        end
        S_SCREEN: begin
          if (!w_live) begin
            r_state <= S_IDLE;
            plot    <= 1'b0;
            colour  <= 3'b000;
          end else if (x == 8'd159 && y == 7'd119) begin
            plot    <= 1'b0;
            colour  <= 3'b000;
            r_cnt   <= 32'd0;
            r_state <= (r_kind == K_WIN || r_kind == K_GO) ? S_FINAL : S_HOLD;
          end else if (x == 8'd159) begin
            x      <= 8'd0;
            y      <= y + 7'd1;
            colour <= w_col;
          end else begin
            x <= x + 8'd1;
          end
        end
        S_HOLD: begin
          if (!w_live) begin
            r_state <= S_IDLE;
          end else if (r_cnt == HLAST) begin
            if (r_kind == K_TITLE) begin
              r_state <= S_KEYWAIT;
            end else begin
              r_state <= S_PULSE;
              if (r_kind == K_BEGIN) begin_done       <= w_sel;
              if (r_kind == K_DONE)  end_display_done <= w_sel;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_KEYWAIT: begin
          if (!w_live) begin
            r_state <= S_IDLE;
          end else if (start_key) begin
            r_state            <= S_PULSE;
            start_display_done <= 1'b1;
          end
        end
        S_TOWER: begin
          if (!w_live) begin
            r_state <= S_IDLE;
            plot    <= 1'b0;
            colour  <= 3'b000;
          end else if (r_cnt == TLAST) begin
            r_state    <= S_PULSE;
            plot       <= 1'b0;
            colour     <= 3'b000;
            tower_done <= w_sel;
          end else begin
            r_cnt <= w_nidx;
            x     <= w_tx;
            y     <= w_ty;
          end
        end
        S_PLAY: begin
          if (!w_live) begin
            r_state <= S_IDLE;
          end else begin
            r_rem   <= w_rem_n;
            r_lives <= w_liv_n;
            if (w_liv_n == 8'd0) begin
              game_over_in <= 1'b1;
              r_state      <= S_FINAL;
            end else if (w_rem_n == 8'd0) begin
              car_done <= w_sel;
              r_state  <= S_PULSE;
            end
          end
        end
        S_PULSE: r_state <= S_REARM;
        S_REARM: if (!w_live) r_state <= S_IDLE;
        S_FINAL: plot <= 1'b0;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_responder.sv
// Directed bench for game_flow_responder.
// Small hold count, hand-computed cycle expectations.
module tb_game_flow_responder;

  logic       clk = 1'b0;
  logic       resetn;
  logic       wait_start;
  logic [2:0] stage_begin;
  logic [2:0] stage_draw_tower;
  logic [2:0] stage_in_progress;
  logic [2:0] stage_done;
  logic       win;
  logic       game_over_out;
  logic       start_key;
  logic       car_killed;
  logic       car_escaped;
  logic       start_display_done;
  logic [2:0] begin_done;
  logic [2:0] tower_done;
  logic [2:0] car_done;
  logic [2:0] end_display_done;
  logic       game_over_in;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  int n_vec = 0;
  int n_err = 0;

  game_flow_responder #(
    .HOLD_CYCLES(4), .CARS_PER_STAGE(8), .LIVES(3), .NUM_TOWERS(4)
  ) dut (
    .clk(clk), .resetn(resetn),
    .wait_start(wait_start), .stage_begin(stage_begin),
    .stage_draw_tower(stage_draw_tower),
    .stage_in_progress(stage_in_progress),
    .stage_done(stage_done), .win(win),
    .game_over_out(game_over_out), .start_key(start_key),
    .car_killed(car_killed), .car_escaped(car_escaped),
    .start_display_done(start_display_done),
    .begin_done(begin_done), .tower_done(tower_done),
    .car_done(car_done), .end_display_done(end_display_done),
    .game_over_in(game_over_in), .plot(plot),
    .x(x), .y(y), .colour(colour)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wait_start        = 1'b0;
    stage_begin       = 3'b000;
    stage_draw_tower  = 3'b000;
    stage_in_progress = 3'b000;
    stage_done        = 3'b000;
    win               = 1'b0;
    game_over_out     = 1'b0;
    start_key         = 1'b0;
    car_killed        = 1'b0;
    car_escaped       = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  function automatic int all_out();
    return int'({start_display_done, begin_done, tower_done, car_done,
                 end_display_done, game_over_in, plot, x, y, colour});
  endfunction

  initial begin
    int pc, dc, dcyc, lcyc, lx, ly, fx, fy, bad;
    idle_inputs();
    do_reset();
    chk("reset_outputs", all_out(), 0);

    // title screen, no key for 30000 cycles
    wait_start = 1'b1;
    pc = 0; dc = 0;
    for (int c = 1; c <= 30000; c++) begin
      tick();
      if (plot && colour == 3'b001) pc++;
      if (start_display_done) dc++;
    end
    chk("title_plots", pc, 19200);
    chk("title_no_done", dc, 0);
    start_key = 1'b1;
    dc = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (start_display_done) dc++;
    end
    chk("title_key_done", dc, 1);
    idle_inputs();
    tick(); tick();

    // stage 1 begin screen with exact timing
    stage_begin = 3'b001;
    tick();
    chk("begin_first_plot", int'(plot), 1);
    chk("begin_first_xy", int'({x, y}), 0);
    chk("begin_colour", int'(colour), 2);
    lcyc = 1; dcyc = -1; dc = 0; lx = 0; ly = 0;
    for (int c = 2; c <= 19230; c++) begin
      tick();
      if (plot) begin lcyc = c; lx = x; ly = y; end
      if (begin_done != 3'b000) begin
        dc++;
        dcyc = c;
        chk("begin_done_bit", int'(begin_done), 1);
      end
    end
    chk("begin_last_cycle", lcyc, 19200);
    chk("begin_last_x", lx, 159);
    chk("begin_last_y", ly, 119);
    chk("begin_done_cycle", dcyc, 19205);
    chk("begin_done_once", dc, 1);
    idle_inputs();
    tick(); tick();

    // stage 2 tower draw
    stage_draw_tower = 3'b010;
    pc = 0; dc = 0; dcyc = -1; fx = -1; fy = -1; bad = 0;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (plot) begin
        if (pc == 0) begin fx = x; fy = y; end
        if (colour != 3'b011) bad++;
        pc++; lx = x; ly = y;
      end
      if (tower_done != 3'b000) begin
        dc++;
        dcyc = c;
        chk("tower_done_bit", int'(tower_done), 2);
      end
    end
    chk("tower_plots", pc, 256);
    chk("tower_colour_bad", bad, 0);
    chk("tower_first_x", fx, 16);
    chk("tower_first_y", fy, 56);
    chk("tower_last_x", lx, 119);
    chk("tower_last_y", ly, 63);
    chk("tower_done_cycle", dcyc, 257);
    chk("tower_done_once", dc, 1);
    idle_inputs();
    tick(); tick();

    // stage 1 play loads lives, 8 kills finish it
    stage_in_progress = 3'b001;
    tick();
    dc = 0;
    for (int k = 1; k <= 8; k++) begin
      car_killed = 1'b1;
      tick();
      car_killed = 1'b0;
      if (car_done != 3'b000) begin
        dc++;
        chk("s1_car_done_k", k, 8);
        chk("s1_car_done_bit", int'(car_done), 1);
      end
    end
    chk("s1_car_done_once", dc, 1);
    idle_inputs();
    tick(); tick();

    // stage 3 play with carried lives: 24 kills
    stage_in_progress = 3'b100;
    tick();
    dc = 0;
    for (int k = 1; k <= 23; k++) begin
      car_killed = 1'b1;
      tick();
      car_killed = 1'b0;
      if (car_done != 3'b000) dc++;
      tick();
      if (car_done != 3'b000) dc++;
    end
    chk("s3_no_early_done", dc, 0);
    chk("s3_no_game_over", int'(game_over_in), 0);
    car_killed = 1'b1;
    tick();
    car_killed = 1'b0;
    chk("s3_car_done", int'(car_done), 4);
    tick();
    chk("s3_car_done_1cyc", int'(car_done), 0);
    idle_inputs();
    tick(); tick();

    // losing all lives in stage 1
    do_reset();
    stage_in_progress = 3'b001;
    tick();
    for (int k = 1; k <= 2; k++) begin
      car_escaped = 1'b1;
      tick();
      car_escaped = 1'b0;
    end
    chk("go_after_two", int'(game_over_in), 0);
    car_escaped = 1'b1;
    tick();
    car_escaped = 1'b0;
    chk("go_after_three", int'(game_over_in), 1);
    dc = 0;
    for (int k = 0; k < 10; k++) begin
      car_killed = 1'b1;
      tick();
      if (car_done != 3'b000) dc++;
    end
    car_killed = 1'b0;
    chk("go_no_car_done", dc, 0);
    chk("go_held", int'(game_over_in), 1);

    // reset mid-screen, then restart
    idle_inputs();
    do_reset();
    stage_begin = 3'b001;
    for (int c = 1; c <= 501; c++) tick();
    chk("mid_x", int'(x), 20);
    chk("mid_y", int'(y), 3);
    resetn = 1'b0;
    tick();
    chk("mid_reset_out", all_out(), 0);
    resetn = 1'b1;
    tick();
    chk("restart_plot", int'(plot), 1);
    chk("restart_xy", int'({x, y}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_flow_responder.md
Name: game_flow_responder

Overview:
- Responder side of the game-flow control interface.
- Consumes the one-hot phase signals issued by the game-flow controller: wait_start, stage_N_begin/draw_tower/in_progress/done, win, game_over_out.
- For each phase it performs that phase's work (full-screen draw, tower draw, car/lives bookkeeping), then returns the matching done/terminal feedback.
- Sits between the controller FSM and the VGA adapter, on the same clock.

Parameters:
HOLD_CYCLES, 25000000, cycles a drawn screen is held before its done pulse (benches use 4)
CARS_PER_STAGE, 8, cars per stage unit; stage N resolves N*CARS_PER_STAGE cars
LIVES, 3, lives loaded on the stage-1 in-progress entry
NUM_TOWERS, 4, towers drawn per tower phase

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
wait_start  in  1  controller phase: title screen
stage_begin  in  3  bit N-1 = stage_N_begin
stage_draw_tower  in  3  bit N-1 = stage_N_draw_tower
stage_in_progress  in  3  bit N-1 = stage_N_in_progress
stage_done  in  3  bit N-1 = stage_N_done
win  in  1  controller terminal win
game_over_out  in  1  controller terminal loss
start_key  in  1  player start, level
car_killed  in  1  one-cycle pulse, a car was destroyed
car_escaped  in  1  one-cycle pulse, a car reached the exit
start_display_done  out  1  feedback pulse
begin_done  out  3  stage_N_begin_done pulses
tower_done  out  3  stage_N_tower_done pulses
car_done  out  3  stage_N_car_done pulses
end_display_done  out  3  stage_N_end_display_done pulses
game_over_in  out  1  level, lives exhausted
plot  out  1  VGA write enable
x  out  8  pixel column 0..159
y  out  7  pixel row 0..119
colour  out  3  pixel colour

Behaviour:
- Reset (resetn low at an edge): all outputs 0, FSM IDLE, counters 0, lives 0, game_over_in 0. Reset mid-draw or mid-hold aborts immediately with no done pulse.
- Request = the active phase input. Priority for illegal multi-hot: wait_start > begin > draw_tower > in_progress > done > win > game_over_out, lower stage index first within a group.
- FSM states: IDLE, SCREEN, HOLD, KEYWAIT, TOWER, PLAY, PULSE, FINAL, REARM.
- IDLE: on the first cycle a request is sampled high, latch its id.
  - Screen-type request (wait_start, begin, done, win, game_over_out) -> SCREEN.
  - draw_tower -> TOWER.
  - in_progress -> PLAY.
- SCREEN: raster sweep of 19200 pixels, x fastest. First pixel (0,0) is driven on the cycle after the request is sampled. plot=1 every SCREEN cycle. Colour by id: title 3'b001, begin 3'b010, done 3'b110, win 3'b111, game-over 3'b100. After (159,119): plot=0.
  - win / game_over_out -> FINAL.
  - Others -> HOLD.
- HOLD: count HOLD_CYCLES, then:
  - wait_start -> KEYWAIT.
  - Others -> PULSE.
- KEYWAIT: -> PULSE when start_key=1.
- TOWER: draw NUM_TOWERS 8x8 squares at x=16+32*i, y=56..63, colour 3'b011. Row-major within each square, towers in ascending i, 64*NUM_TOWERS plot cycles. Then -> PULSE (no hold).
- PULSE: matching done bit high for exactly one cycle -> REARM.
- REARM: wait until the latched request input is low -> IDLE. This prevents retrigger while the controller has not yet left the state.
- FINAL: plot=0; absorbing until reset.
- PLAY:
  - Entry cycle: remaining = N*CARS_PER_STAGE (8-bit). Lives load LIVES on the stage-1 entry; for stages 2 and 3 they are carried over.
  - Each cycle: remaining -= car_killed + car_escaped, saturating at 0; lives -= car_escaped, saturating at 0.
  - New lives==0 -> game_over_in=1, held until reset; -> FINAL.
  - Else new remaining==0 -> PULSE (car_done[N-1]).
  - Game over wins when both conditions occur in the same cycle; car_done is never asserted with game_over_in.
  - Pulses outside PLAY are ignored.
- Exactly one done bit may be high in any cycle.
- Requests that deassert before completion abort to IDLE with no pulse.

Test Plan:
- HOLD_CYCLES=4. wait_start=1, start_key=0 for 30000 cycles -> 19200 plot cycles of colour 001, then no start_display_done. Raise start_key -> start_display_done=1 for exactly one cycle.
- stage_begin=3'b001 sampled at cycle 0 -> (0,0) at cycle 1, last pixel at cycle 19200, begin_done[0] one-cycle pulse at cycle 19205. Holding the request high afterward yields no second pulse.
- stage_draw_tower=3'b010 -> 256 plot cycles, first pixel (16,56), last (119,63), then tower_done[1] pulse.
- stage_in_progress=3'b100 with lives=3 carried -> 23 car_killed pulses give no response; the 24th gives car_done[2] pulse.
- stage 1 PLAY: car_escaped x3 -> game_over_in=1 after third; subsequent car_killed ignored; no car_done.
- Reset asserted mid-SCREEN at pixel 500 -> next cycle plot=0, all outputs 0; re-request restarts at (0,0).
